// File: rtl/demux_dispatch_pkg.sv
// Shared types and constants for the demux_dispatch block.
package demux_dispatch_pkg;
  localparam int NUM_DEST = 4;
  localparam int SEL_W    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/demux_dispatch_rr_pick.sv
// Combinational round-robin picker: first set mask bit at start, start+1, ... mod NUM_DEST.
module rr_pick
  import demux_dispatch_pkg::*;
(
  input  logic [NUM_DEST-1:0] mask,
  input  logic [SEL_W-1:0]    start,
  output logic [SEL_W-1:0]    idx,
  output logic                found
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the nearest eligible index wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NUM_DEST - 1; k >= 0; k--) begin
      cand = start + SEL_W'(k);
      if (mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_dispatch.sv
// One-word demux dispatcher with round-robin destination choice.
// Optional per-destination delivery counters under `DEMUX_DISPATCH_STATS_EN.
module demux_dispatch
  import demux_dispatch_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_DEST-1:0]        en_mask,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic [NUM_DEST-1:0]        out_valid,
  input  logic [NUM_DEST-1:0]        out_ready,
  output logic [NUM_DEST*DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]           sel,
  output logic                       busy,
  output logic [NUM_DEST*CNT_W-1:0]  cnt
);

  // Handshake: a word moves on in_valid && in_ready (input side) and on
  // out_valid[sel] && out_ready[sel] (output side); the held word stays put otherwise.

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic               mask_any;
  logic               complete;
  logic               in_ready_c;
  logic               accept;
  logic [SEL_W-1:0]   start;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_found;

  rr_pick u_rr_pick (
    .mask  (en_mask),
    .start (start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    mask_any   = |en_mask;
    complete   = (state_q == HOLD) && out_ready[sel_q];
    // Back-to-back selection continues from the lane just completed.
    start      = (state_q == HOLD) ? (sel_q + SEL_W'(1)) : ptr_q;
    in_ready_c = (state_q == IDLE) ? mask_any : (complete && mask_any);
    accept     = in_valid && in_ready_c && pick_found;

    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    if (complete) begin
      ptr_d   = sel_q + SEL_W'(1);
      state_d = IDLE;
    end
    if (accept) begin
      state_d = HOLD;
      sel_d   = pick_idx;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    in_ready  = in_ready_c && !rst;
    busy      = (state_q == HOLD) && !rst;
    sel       = sel_q;
    out_valid = busy ? (NUM_DEST'(1) << sel_q) : '0;
    out_data  = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (out_valid[i]) out_data[i*DATA_W +: DATA_W] = data_q;
    end
  end

`ifdef DEMUX_DISPATCH_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_DEST];
  logic [CNT_W-1:0] cnt_d [NUM_DEST];

  always_comb begin
    for (int i = 0; i < NUM_DEST; i++) cnt_d[i] = cnt_q[i];
    if (complete) cnt_d[sel_q] = cnt_q[sel_q] + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_DEST; i++) begin
      if (rst) cnt_q[i] <= '0;
      else     cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DEST; i++) cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`else
  assign cnt = '0;
`endif

endmodule

// File: tb/tb_demux_dispatch.sv
// Directed bench for demux_dispatch: vector table plus hand sequences for stalls, masks and reset.
module tb_demux_dispatch;
  localparam int DATA_W = 1;
  localparam int CNT_W  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en_mask;
  logic        in_valid;
  logic        in_ready;
  logic        in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [3:0]  out_data;
  logic [1:0]  sel;
  logic        busy;
  logic [31:0] cnt;

  int checks = 0;
  int passes = 0;

  demux_dispatch #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_mask   (en_mask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy),
    .cnt       (cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic       d;
    logic [3:0] m;
    logic [3:0] orr;
    logic       e_ir;
    logic [3:0] e_ov;
    logic [3:0] e_od;
    logic [1:0] e_sel;
    logic       e_busy;
  } vec_t;

  vec_t tbl[11];

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic d, input logic [3:0] m, input logic [3:0] orr);
    in_valid  = iv;
    in_data   = d;
    en_mask   = m;
    out_ready = orr;
    #1;
  endtask

  // Scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input logic ir, input logic [3:0] ov,
                         input logic [3:0] od, input logic [1:0] s, input logic b);
    chk({tag, " in_ready"},  32'(in_ready),  32'(ir));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, " out_data"},  32'(out_data),  32'(od));
    chk({tag, " sel"},       32'(sel),       32'(s));
    chk({tag, " busy"},      32'(busy),      32'(b));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 4'b1111, 4'b1111);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 4'b0000);
  endtask

  initial begin
    // Four words 1,0,1,1 over all lanes, then mask 1010 giving lanes 1,3,1.
    tbl[0]  = '{1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0010, 4'b0000, 2'd1, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 4'b1010, 4'b1111, 1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 4'b1010, 4'b1111, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 4'b1010, 4'b1111, 1'b1, 4'b1000, 4'b0000, 2'd3, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 4'b1010, 4'b1111, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 4'b1010, 4'b1111, 1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0};

    rst = 1'b1;
    drive(1'b1, 1'b1, 4'b1111, 4'b1111);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    tick();
    chk_out("reset", 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    chk("reset cnt", cnt, 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 4'b0000);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].m, tbl[i].orr);
      chk_out($sformatf("vec%0d", i), tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_od, tbl[i].e_sel, tbl[i].e_busy);
      tick();
    end

    // Stall on lane 2 while other lanes' out_ready toggle.
    drive(1'b1, 1'b1, 4'b0100, 4'b0000);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b0, 4'b0100, {c[0], 1'b0, ~c[0], c[0]});
      chk_out($sformatf("stall%0d", c), 1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 4'b0100, 4'b0100);
    chk_out("stall release", 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1);
    tick();
    chk_out("stall done", 1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0);

    // Empty mask blocks acceptance; enabling lane 2 lets the word through.
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, 4'b0000, 4'b1111);
      chk($sformatf("nomask%0d in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("nomask%0d out_valid", c), 32'(out_valid), 32'd0);
      tick();
    end
    drive(1'b1, 1'b1, 4'b0100, 4'b0000);
    chk("mask on in_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 1'b0, 4'b0000, 4'b0100);
    chk_out("held mask0", 1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'b0000, 4'b0000);
    chk_out("held mask0 done", 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);

    // Reset during HOLD drops the word; next pick restarts from index 0.
    drive(1'b1, 1'b1, 4'b1111, 4'b0000);
    tick();
    drive(1'b0, 1'b0, 4'b1111, 4'b0000);
    chk_out("pre rst hold", 1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst cycle in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b1, 4'b1100, 4'b0000);
    chk_out("post rst", 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'b1100, 4'b0100);
    chk_out("post rst word", 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1);
    tick();
    chk("post rst idle busy", 32'(busy), 32'd0);

`ifdef DEMUX_DISPATCH_STATS_EN
    do_reset();
    for (int c = 0; c < 257; c++) begin
      drive(1'b1, c[0], 4'b0001, 4'b1111);
      tick();
    end
    drive(1'b0, 1'b0, 4'b0001, 4'b1111);
    tick();
    chk("cnt lane0 wrap", cnt, 32'h0000_0001);
    do_reset();
    drive(1'b1, 1'b1, 4'b1010, 4'b1111);
    tick();
    tick();
    drive(1'b0, 1'b0, 4'b1010, 4'b1111);
    tick();
    chk("cnt lanes 1 and 3", cnt, 32'h0100_0100);
`else
    chk("cnt tied off", cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/demux_dispatch.md
DEMUX_DISPATCH -- requirements
Module: demux_dispatch

Interface
REQ-001 SHALL have parameter DATA_W, default 1: width of the dispatched data word.
REQ-002 SHALL have parameter CNT_W, default 8: width of each per-destination delivery counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en_mask, input, 4 bits: destination i is eligible when en_mask[i]=1.
REQ-006 SHALL have port in_valid, input, 1 bit: source offers in_data.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-008 SHALL have port in_data, input, DATA_W bits: source word.
REQ-009 SHALL have port out_valid, output, 4 bits: one-hot or zero; bit i means lane i holds a word.
REQ-010 SHALL have port out_ready, input, 4 bits: per-destination accept.
REQ-011 SHALL have port out_data, output, 4*DATA_W bits: lane i is bits [i*DATA_W +: DATA_W]; non-selected lanes are driven to 0.
REQ-012 SHALL have port sel, output, 2 bits: index of the current or last destination (demux control code).
REQ-013 SHALL have port busy, output, 1 bit: high in HOLD.
REQ-014 SHALL have port cnt, output, 4*CNT_W bits: lane i is the delivery count for destination i (see REQ-027).

Function
REQ-015 SHALL implement FSM states IDLE and HOLD.
REQ-016 In IDLE, in_ready SHALL equal (en_mask != 0).
REQ-017 On in_valid && in_ready in IDLE, SHALL capture in_data, set sel to the first index with en_mask=1 searching ptr, ptr+1, ... modulo 4, and enter HOLD.
REQ-018 In HOLD, out_valid SHALL be one-hot at bit sel and out_data lane sel SHALL equal the captured word, with latency of exactly 1 cycle from acceptance.
REQ-019 Held word and sel SHALL stay stable in HOLD until out_ready[sel]=1; out_ready on other lanes SHALL be ignored.
REQ-020 On completion (HOLD && out_ready[sel]), ptr SHALL become (sel+1) mod 4, wrapping 3 to 0.
REQ-021 In HOLD, in_ready SHALL equal out_ready[sel] && (en_mask != 0). On completion with in_valid=1, a new word SHALL be accepted in the same cycle, and SHALL stay in HOLD with a new sel searched from (sel+1) mod 4 using the current en_mask (back-to-back, 1 word/cycle). Otherwise, on completion, SHALL return to IDLE.
REQ-022 en_mask changes during HOLD SHALL NOT cancel or redirect the held word; the new mask applies only to the next selection.
REQ-023 With en_mask=0, no word SHALL be accepted; an already held word SHALL still complete.
REQ-024 busy SHALL be 1 exactly in HOLD.

Reset
REQ-025 While rst=1, the block SHALL be forced to: state IDLE, ptr=0, sel=0, out_valid=0, out_data=0, held word=0, busy=0, and in_ready=0 during the reset cycle.
REQ-026 A reset asserted during HOLD SHALL drop the held word with no completion or count; out_valid SHALL be 0 from the next edge onward.

Configuration
REQ-027 Macro DEMUX_DISPATCH_STATS_EN defined: four CNT_W counters SHALL each increment on completion to their destination, wrapping modulo 2^CNT_W, and SHALL reset to 0.
REQ-028 Macro DEMUX_DISPATCH_STATS_EN undefined: cnt SHALL be tied to 0 and no counter flops SHALL be synthesized.

Structure
REQ-029 Package demux_dispatch_pkg SHALL hold the state enum (IDLE, HOLD), NUM_DEST=4 and SEL_W=2.
REQ-030 Sub-module rr_pick SHALL be combinational: inputs are the 4-bit mask and a 2-bit start pointer; outputs are the 2-bit index and a found flag.

Verification
REQ-031 Reset, then en_mask=4'b1111, send words 1,0,1,1 with all out_ready=1 -> out_valid 0001,0010,0100,1000, one per cycle, data matches.
REQ-032 en_mask=4'b1010, ptr=0, send 3 words -> destinations 1,3,1 (wrap from 3 back to 1).
REQ-033 Hold out_ready[2]=0 for 5 cycles with sel=2 while toggling out_ready[0] -> out_valid stays 0100, data stable, in_ready=0, then completion on release.
REQ-034 en_mask=0 with in_valid=1 -> in_ready=0 and out_valid=0 indefinitely; set en_mask=4'b0100 -> word delivered on lane 2.
REQ-035 rst=1 during HOLD -> next cycle out_valid=0, busy=0; first post-reset word goes to the lowest enabled index at or above 0.
REQ-036 With DEMUX_DISPATCH_STATS_EN and CNT_W=8, deliver 257 words to lane 0 only -> cnt lane 0 = 1, other lanes 0.
